frq_meter_bcd: RTL and testbench

- Frequency meter: counts rising edges of an external signal over a fixed gate window of mclk cycles.
- Presents the count as packed BCD digits for the seven-segment display path.
- Performs the inverse of the frequency divider: measures an unknown rate instead of producing a derived one.
- Output feeds the segment mux/decoder directly; no binary-to-BCD conversion downstream.

---
 rtl/frq_meter_bcd.sv | 106 ++++++++++
 tb/tb_frq_meter_bcd.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/frq_meter_bcd.sv
// Frequency meter: counts sig_in rising edges over a GATE_CYCLES window into a DIGITS-wide BCD counter.
// Optional FRQ_METER_BLANK_EN: leading-zero digits are latched as 4'hF (blank code).
module frq_meter_bcd #(
    parameter int GATE_CYCLES = 1000,
    parameter int DIGITS      = 4
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  sig_in,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  valid,
    output logic                  overflow
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    logic                r_s1, r_s2, r_s3;
    logic [GW-1:0]       r_gate;
    logic [4*DIGITS-1:0] r_acc;
    logic                r_sat;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_valid;
    logic                r_ovf;

    logic                w_edge;
    logic                w_close;
    logic                w_all9;
    logic                w_carry;
    logic [4*DIGITS-1:0] w_acc_inc;
    logic [4*DIGITS-1:0] w_acc_nx;
    logic [4*DIGITS-1:0] w_latch;

    assign w_edge  = r_s2 & ~r_s3;
    assign w_close = (r_gate == GATE_LAST);

    // Ripple decimal carry; at all 9s the count freezes instead of wrapping.
    always_comb begin
        w_acc_inc = r_acc;
        w_carry   = w_edge;
        w_all9    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_acc[4*k +: 4] != 4'd9) w_all9 = 1'b0;
            if (w_carry) begin
                if (r_acc[4*k +: 4] == 4'd9) begin
                    w_acc_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_acc_inc[4*k +: 4] = r_acc[4*k +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
        w_acc_nx = w_all9 ? r_acc : w_acc_inc;
    end

`ifdef FRQ_METER_BLANK_EN
    logic w_lead;

    always_comb begin
        w_latch = w_acc_nx;
        w_lead  = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            if (w_lead && (w_acc_nx[4*k +: 4] == 4'd0)) w_latch[4*k +: 4] = 4'hF;
            else                                        w_lead = 1'b0;
        end
    end
`else
    assign w_latch = w_acc_nx;
`endif

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_gate  <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
            r_bcd   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_s1    <= sig_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_valid <= w_close;
            if (w_close) begin
                // Edge seen in the close cycle belongs to the window being closed.
                r_gate <= '0;
                r_bcd  <= w_latch;
                r_ovf  <= r_sat | (w_all9 & w_edge);
                r_acc  <= '0;
                r_sat  <= 1'b0;
            end else begin
                r_gate <= r_gate + GW'(1);
                r_acc  <= w_acc_nx;
                if (w_all9 & w_edge) r_sat <= 1'b1;
            end
        end
    end

    assign bcd      = r_bcd;
    assign valid    = r_valid;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_frq_meter_bcd.sv
// Directed bench for frq_meter_bcd: three instances (100/4, 1000/4, 300/2) share clock and reset.
module tb_frq_meter_bcd;

`ifdef FRQ_METER_BLANK_EN
    localparam logic [15:0] E10 = 16'hFF10, E1 = 16'hFFF1, E0 = 16'hFFF0, E7 = 16'hFFF7;
    localparam logic [15:0] E500 = 16'hF500, E250 = 16'hF250;
    localparam logic [7:0]  E99 = 8'h99, E00 = 8'hF0;
`else
    localparam logic [15:0] E10 = 16'h0010, E1 = 16'h0001, E0 = 16'h0000, E7 = 16'h0007;
    localparam logic [15:0] E500 = 16'h0500, E250 = 16'h0250;
    localparam logic [7:0]  E99 = 8'h99, E00 = 8'h00;
`endif

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic        sig_a = 1'b0, sig_b = 1'b0, sig_c = 1'b0;
    logic [15:0] bca, bcb;
    logic [7:0]  bcc;
    logic        va, vb, vc, ova, ovb, ovc;

    int          pa = 10, pb = 0, pc = 0;
    int          ca = 0, cb = 0, cc = 0;
    logic        frc_en = 1'b0, frc_val = 1'b0;
    int          n_vec = 0, n_err = 0;
    int          n;

    always #5 mclk = ~mclk;

    frq_meter_bcd #(.GATE_CYCLES(100), .DIGITS(4)) u_a (
        .mclk(mclk), .reset(reset), .sig_in(sig_a), .bcd(bca), .valid(va), .overflow(ova));
    frq_meter_bcd #(.GATE_CYCLES(1000), .DIGITS(4)) u_b (
        .mclk(mclk), .reset(reset), .sig_in(sig_b), .bcd(bcb), .valid(vb), .overflow(ovb));
    frq_meter_bcd #(.GATE_CYCLES(300), .DIGITS(2)) u_c (
        .mclk(mclk), .reset(reset), .sig_in(sig_c), .bcd(bcc), .valid(vc), .overflow(ovc));

    task automatic gen_step(input int p, inout int c, inout logic s);
        if (p == 0) begin
            s = 1'b0;
            c = 0;
        end else begin
            c++;
            if (c >= p / 2) begin
                s = ~s;
                c = 0;
            end
        end
    endtask

    // Inputs change on the falling edge only.
    initial begin
        forever begin
            @(negedge mclk);
            if (frc_en) sig_a = frc_val;
            else        gen_step(pa, ca, sig_a);
            gen_step(pb, cb, sig_b);
            gen_step(pc, cc, sig_c);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge mclk);
            #1;
        end
    endtask

    function automatic logic vld_of(input int which);
        return (which == 0) ? va : (which == 1) ? vb : vc;
    endfunction

    task automatic wait_vld(input int which, input string tag, output int ncyc);
        bit seen = 0;
        ncyc = 0;
        while (!seen && ncyc < 1200) begin
            cyc(1);
            ncyc++;
            if (vld_of(which)) seen = 1;
        end
        if (!seen) chk({tag, "_tmo"}, 32'(vld_of(which)), 32'd1);
    endtask

    initial begin
        // Reset held while sig_a toggles.
        cyc(5);
        chk("rst_bcd", 32'(bca), 32'd0);
        chk("rst_vld", 32'(va), 32'd0);
        chk("rst_ovf", 32'(ova), 32'd0);
        @(negedge mclk);
        reset = 1'b0;
        wait_vld(0, "first", n);
        chk("first_lat", 32'(n), 32'd100);
        cyc(1);
        chk("vld_width", 32'(va), 32'd0);

        // Period-10 input: 10 edges per 100-cycle window.
        for (int w = 0; w < 2; w++) begin
            wait_vld(0, "p10", n);
            chk("p10_lat", 32'(n), 32'd99);
            chk("p10_bcd", 32'(bca), 32'(E10));
            chk("p10_ovf", 32'(ova), 32'd0);
            cyc(1);
        end

        // Quiet sig_a, drain one window, then a pulse landing in the close cycle.
        frc_en  = 1'b1;
        frc_val = 1'b0;
        wait_vld(0, "drain", n);
        cyc(97);
        frc_val = 1'b1;
        cyc(3);
        chk("close_vld", 32'(va), 32'd1);
        chk("close_bcd", 32'(bca), 32'(E1));
        frc_val = 1'b0;
        wait_vld(0, "after", n);
        chk("after_bcd", 32'(bca), 32'(E0));

        // Seven pulses in a window.
        for (int i = 0; i < 7; i++) begin
            frc_val = 1'b1; cyc(2);
            frc_val = 1'b0; cyc(2);
        end
        wait_vld(0, "seven", n);
        chk("seven_bcd", 32'(bca), 32'(E7));

        // Seven more, then a one-cycle reset mid-window.
        for (int i = 0; i < 7; i++) begin
            frc_val = 1'b1; cyc(2);
            frc_val = 1'b0; cyc(2);
        end
        cyc(20);
        @(negedge mclk);
        reset = 1'b1;
        #1;
        chk("mid_rst_bcd", 32'(bca), 32'd0);
        chk("mid_rst_vld", 32'(va), 32'd0);
        chk("mid_rst_ovf", 32'(ova), 32'd0);
        @(negedge mclk);
        reset = 1'b0;
        wait_vld(0, "restart", n);
        chk("restart_lat", 32'(n), 32'd100);
        chk("restart_bcd", 32'(bca), 32'(E0));

        // 1000-cycle gate: period 2 then period 4.
        pb = 2;
        pc = 2;
        wait_vld(1, "b_skip", n);
        wait_vld(1, "b500", n);
        chk("b500_bcd", 32'(bcb), 32'(E500));
        chk("b500_ovf", 32'(ovb), 32'd0);
        pb = 4;
        wait_vld(1, "b_skip2", n);
        wait_vld(1, "b250", n);
        chk("b250_bcd", 32'(bcb), 32'(E250));

        // Two-digit meter saturates at 99, then recovers once input stops.
        wait_vld(2, "c_skip", n);
        wait_vld(2, "c99", n);
        chk("c99_bcd", 32'(bcc), 32'(E99));
        chk("c99_ovf", 32'(ovc), 32'd1);
        pc = 0;
        wait_vld(2, "c_skip2", n);
        wait_vld(2, "c00", n);
        chk("c00_bcd", 32'(bcc), 32'(E00));
        chk("c00_ovf", 32'(ovc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
